dma_bus_engine: RTL

Bus-master side of the DMA custom instruction. It takes the configuration the CPU programs through the custom-instruction interface: bus start address, memory start address, block size, burst size and control. It then moves the block between port B of the 512x32 local SSRAM and the system bus in bursts. It also reports busy/error status back to the CPU-side register file.

---
 rtl/dma_pkg.sv | 34 +++
 rtl/dma_bus_engine_if.sv | 33 +++
 rtl/dma_bus_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA custom instruction: widths, FSM states and the
// CPU-side register map.
package dma_pkg;

  localparam int unsigned MemAddrWidth   = 9;
  localparam int unsigned BlockSizeWidth = 10;
  localparam int unsigned BurstSizeWidth = 8;
  localparam int unsigned BusWidth       = 32;

  // Control register bit positions
  localparam int unsigned CtrlStartBit     = 0;
  localparam int unsigned CtrlDirectionBit = 1;

  typedef enum logic [2:0] {
    OpMem        = 3'd0,
    OpBusStart   = 3'd1,
    OpMemStart   = 3'd2,
    OpBlockSize  = 3'd3,
    OpBurstSize  = 3'd4,
    OpControl    = 3'd5
  } opT;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StBegin,
    StReadBeats,
    StWriteFetch,
    StWriteBeats,
    StEndWrite,
    StDone
  } stateT;

endpackage

// File: rtl/dma_bus_engine_if.sv
// System-bus master/slave signal bundle used by the DMA bus engine.
interface dma_bus_engine_if;
  import dma_pkg::*;

  logic                      requestTransaction;
  logic                      transactionGranted;
  logic                      beginTransactionOut;
  logic [BusWidth-1:0]       addressDataOut;
  logic                      readNotWriteOut;
  logic [BurstSizeWidth-1:0] burstSizeOut;
  logic [3:0]                byteEnablesOut;
  logic                      dataValidOut;
  logic                      endTransactionOut;
  logic [BusWidth-1:0]       addressDataIn;
  logic                      dataValidIn;
  logic                      endTransactionIn;
  logic                      busyIn;
  logic                      busErrorIn;

  modport master (
    output requestTransaction, beginTransactionOut, addressDataOut, readNotWriteOut,
           burstSizeOut, byteEnablesOut, dataValidOut, endTransactionOut,
    input  transactionGranted, addressDataIn, dataValidIn, endTransactionIn, busyIn,
           busErrorIn
  );

  modport slave (
    input  requestTransaction, beginTransactionOut, addressDataOut, readNotWriteOut,
           burstSizeOut, byteEnablesOut, dataValidOut, endTransactionOut,
    output transactionGranted, addressDataIn, dataValidIn, endTransactionIn, busyIn,
           busErrorIn
  );
endinterface

// File: rtl/dma_bus_engine.sv
// DMA bus-master engine: moves a block between SSRAM port B and the system bus
// in bursts, reporting busy/error status to the CPU-side register file.
module dma_bus_engine
  import dma_pkg::*;
#(
  parameter int unsigned memAddrWidth   = MemAddrWidth,
  parameter int unsigned blockSizeWidth = BlockSizeWidth
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BusWidth-1:0]       cfgBusStartAddress,
  input  logic [memAddrWidth-1:0]   cfgMemStartAddress,
  input  logic [blockSizeWidth-1:0] cfgBlockSize,
  input  logic [BurstSizeWidth-1:0] cfgBurstSize,
  input  logic                      cfgStart,
  input  logic                      cfgDirection,
  output logic                      statusBusy,
  output logic                      statusError,
  output logic [memAddrWidth-1:0]   memAddressB,
  output logic                      memWriteEnableB,
  output logic [BusWidth-1:0]       memDataInB,
  input  logic [BusWidth-1:0]       memDataOutB,
  dma_bus_engine_if.master          bus
);

  localparam int unsigned BeatWidth = BurstSizeWidth + 1;

  stateT                     stateQ, stateD;
  logic [BusWidth-1:0]       busAddrQ, busAddrD;
  logic [memAddrWidth-1:0]   memAddrQ, memAddrD;
  logic [blockSizeWidth-1:0] remainingQ, remainingD;
  logic [BurstSizeWidth-1:0] burstSizeQ, burstSizeD;
  logic                      directionQ, directionD;
  logic [BeatWidth-1:0]      beatsLeftQ, beatsLeftD;
  logic [BusWidth-1:0]       holdQ, holdD;
  logic                      holdValidQ, holdValidD;
  logic                      errorQ, errorD;

  logic [BeatWidth-1:0] burstBeats;
  logic [BeatWidth-1:0] beatCount;

  // Beats in the next burst: the programmed burst, clipped by what is left
  always_comb begin
    burstBeats = {1'b0, burstSizeQ} + BeatWidth'(1);
    if (remainingQ < blockSizeWidth'(burstBeats)) begin
      beatCount = BeatWidth'(remainingQ);
    end else begin
      beatCount = burstBeats;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ     <= StIdle;
      busAddrQ   <= '0;
      memAddrQ   <= '0;
      remainingQ <= '0;
      burstSizeQ <= '0;
      directionQ <= 1'b0;
      beatsLeftQ <= '0;
      holdQ      <= '0;
      holdValidQ <= 1'b0;
      errorQ     <= 1'b0;
    end else begin
      stateQ     <= stateD;
      busAddrQ   <= busAddrD;
      memAddrQ   <= memAddrD;
      remainingQ <= remainingD;
      burstSizeQ <= burstSizeD;
      directionQ <= directionD;
      beatsLeftQ <= beatsLeftD;
      holdQ      <= holdD;
      holdValidQ <= holdValidD;
      errorQ     <= errorD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    busAddrD   = busAddrQ;
    memAddrD   = memAddrQ;
    remainingD = remainingQ;
    burstSizeD = burstSizeQ;
    directionD = directionQ;
    beatsLeftD = beatsLeftQ;
    holdD      = holdQ;
    holdValidD = holdValidQ;
    errorD     = errorQ;

    memAddressB             = '0;
    memWriteEnableB         = 1'b0;
    memDataInB              = '0;
    bus.requestTransaction  = 1'b0;
    bus.beginTransactionOut = 1'b0;
    bus.addressDataOut      = '0;
    bus.readNotWriteOut     = 1'b0;
    bus.burstSizeOut        = '0;
    bus.byteEnablesOut      = 4'h0;
    bus.dataValidOut        = 1'b0;
    bus.endTransactionOut   = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (cfgStart) begin
          busAddrD   = cfgBusStartAddress & 32'hFFFF_FFFC;
          memAddrD   = cfgMemStartAddress;
          remainingD = cfgBlockSize;
          burstSizeD = cfgBurstSize;
          directionD = cfgDirection;
          errorD     = 1'b0;
          stateD     = (cfgBlockSize != '0) ? StRequest : StDone;
        end
      end
      StRequest: begin
        bus.requestTransaction = 1'b1;
        if (bus.transactionGranted) stateD = StBegin;
      end
      StBegin: begin
        if (bus.busErrorIn) begin
          errorD = 1'b1;
          stateD = StDone;
        end else begin
          bus.beginTransactionOut = 1'b1;
          bus.addressDataOut      = busAddrQ;
          bus.readNotWriteOut     = ~directionQ;
          bus.burstSizeOut        = BurstSizeWidth'(beatCount - BeatWidth'(1));
          bus.byteEnablesOut      = 4'hF;
          beatsLeftD              = beatCount;
          holdValidD              = 1'b0;
          stateD                  = directionQ ? StWriteFetch : StReadBeats;
        end
      end
      StReadBeats: begin
        if (bus.busErrorIn) begin
          errorD = 1'b1;
          stateD = StDone;
        end else begin
          if (bus.dataValidIn) begin
            memWriteEnableB = 1'b1;
            memAddressB     = memAddrQ;
            memDataInB      = bus.addressDataIn;
            memAddrD        = memAddrQ + memAddrWidth'(1);
            busAddrD        = busAddrQ + 32'd4;
            remainingD      = remainingQ - blockSizeWidth'(1);
          end
          if (bus.endTransactionIn) stateD = (remainingD != '0) ? StRequest : StDone;
        end
      end
      StWriteFetch: begin
        if (bus.busErrorIn) begin
          errorD = 1'b1;
          stateD = StDone;
        end else begin
          memAddressB = memAddrQ;
          stateD      = StWriteBeats;
        end
      end
      StWriteBeats: begin
        if (bus.busErrorIn) begin
          errorD = 1'b1;
          stateD = StDone;
        end else if (!holdValidQ) begin
          holdD      = memDataOutB;
          holdValidD = 1'b1;
        end else begin
          bus.dataValidOut   = 1'b1;
          bus.addressDataOut = holdQ;
          if (!bus.busyIn) begin
            memAddrD   = memAddrQ + memAddrWidth'(1);
            busAddrD   = busAddrQ + 32'd4;
            remainingD = remainingQ - blockSizeWidth'(1);
            beatsLeftD = beatsLeftQ - BeatWidth'(1);
            holdValidD = 1'b0;
            if (beatsLeftQ == BeatWidth'(1)) begin
              stateD = StEndWrite;
            end else begin
              // Prefetch the next word so the gap between beats is one cycle
              memAddressB = memAddrQ + memAddrWidth'(1);
            end
          end
        end
      end
      StEndWrite: begin
        if (bus.busErrorIn) begin
          errorD = 1'b1;
          stateD = StDone;
        end else begin
          bus.endTransactionOut = 1'b1;
          stateD                = (remainingQ != '0) ? StRequest : StDone;
        end
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  assign statusBusy  = (stateQ != StIdle);
  assign statusError = errorQ;

endmodule
